// File: rtl/mig_cp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mig_cp_pkg                                                   |
// | Description : Shared MIG control-plane constants: request source codes and |
// |               the {len, base} table entry layout.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mig_cp_pkg;

    localparam logic SRC_AR = 1'b0;
    localparam logic SRC_AW = 1'b1;

    // Table entries are packed {len, base}: base in the low bits, len directly above.
    localparam int ENTRY_BASE_LSB = 0;

    function automatic int entry_len_lsb(input int base_width);
        return ENTRY_BASE_LSB + base_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mig_cp_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mig_cp_rr_arb2                                               |
// | Description : Two-requester (AR/AW) round-robin arbiter; the last-grant    |
// |               register only moves on a granted handshake.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mig_cp_rr_arb2
    import mig_cp_pkg::*;
(
    input  logic aclk,
    input  logic aresetn,
    input  logic req_ar,
    input  logic req_aw,
    input  logic enable,
    output logic gnt_ar,
    output logic gnt_aw
);

    logic r_last;

    always_comb begin
        gnt_ar = 1'b0;
        gnt_aw = 1'b0;
        if (enable) begin
            if (req_ar && (!req_aw || r_last == SRC_AW)) begin
                gnt_ar = 1'b1;
            end else if (req_aw) begin
                gnt_aw = 1'b1;
            end
        end
    end

    // A grant is only issued to a valid requester, so a grant is a handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_last <= SRC_AW;
        end else if (gnt_ar) begin
            r_last <= SRC_AR;
        end else if (gnt_aw) begin
            r_last <= SRC_AW;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mig_cp_xlat_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mig_cp_xlat_sched                                            |
// | Description : Shares the DSID table lookup port between AR and AW through |
// |               an issue/output pipeline with bounds check and relocation.  |
// |               Optional statistics counters: MIG_CP_XLAT_STATS_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mig_cp_xlat_sched
    import mig_cp_pkg::*;
#(
    parameter int C_TAG_WIDTH    = 16,
    parameter int C_ADDR_WIDTH   = 32,
    parameter int C_BASE_WIDTH   = 32,
    parameter int C_LENGTH_WIDTH = 32,
    parameter int C_CNT_WIDTH    = 32
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic                                 ar_valid,
    output logic                                 ar_ready,
    input  logic [C_TAG_WIDTH-1:0]               ar_tag,
    input  logic [C_ADDR_WIDTH-1:0]              ar_addr,
    input  logic                                 aw_valid,
    output logic                                 aw_ready,
    input  logic [C_TAG_WIDTH-1:0]               aw_tag,
    input  logic [C_ADDR_WIDTH-1:0]              aw_addr,
    output logic [C_TAG_WIDTH-1:0]               tbl_tag,
    input  logic [C_LENGTH_WIDTH+C_BASE_WIDTH-1:0] tbl_data,
    input  logic                                 tbl_match,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [C_ADDR_WIDTH-1:0]              m_addr,
    output logic                                 m_src,
    output logic                                 m_fault,
    output logic [C_CNT_WIDTH-1:0]               stat_xlat_cnt,
    output logic [C_CNT_WIDTH-1:0]               stat_fault_cnt
);

    localparam int C_LEN_LSB = entry_len_lsb(C_BASE_WIDTH);

    logic                    r_a_valid, r_a_src;
    logic [C_TAG_WIDTH-1:0]  r_a_tag;
    logic [C_ADDR_WIDTH-1:0] r_a_addr;
    logic                    r_b_valid, r_b_src, r_b_fault;
    logic [C_ADDR_WIDTH-1:0] r_b_addr;

    logic w_b_load, w_a_load, w_a_to_b, w_gnt_ar, w_gnt_aw, w_hs, w_fault;
    logic [C_BASE_WIDTH-1:0]   w_tbl_base;
    logic [C_LENGTH_WIDTH-1:0] w_tbl_len;
    logic [C_ADDR_WIDTH-1:0]   w_base, w_len;
    logic [C_ADDR_WIDTH:0]     w_sum;

    assign w_b_load = !r_b_valid || m_ready;
    assign w_a_load = !r_a_valid || w_b_load;
    assign w_a_to_b = r_a_valid && w_b_load;
    assign w_hs     = w_gnt_ar || w_gnt_aw;

    mig_cp_rr_arb2 u_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req_ar  (ar_valid),
        .req_aw  (aw_valid),
        .enable  (w_a_load),
        .gnt_ar  (w_gnt_ar),
        .gnt_aw  (w_gnt_aw)
    );

    assign ar_ready = w_gnt_ar;
    assign aw_ready = w_gnt_aw;
    assign tbl_tag  = r_a_valid ? r_a_tag : '0;

    assign w_tbl_base = tbl_data[ENTRY_BASE_LSB +: C_BASE_WIDTH];
    assign w_tbl_len  = tbl_data[C_LEN_LSB +: C_LENGTH_WIDTH];

    // Fit table fields to the address width (truncate or zero-extend).
    generate
        if (C_BASE_WIDTH >= C_ADDR_WIDTH) begin : g_base_trunc
            assign w_base = w_tbl_base[C_ADDR_WIDTH-1:0];
        end else begin : g_base_ext
            assign w_base = {{(C_ADDR_WIDTH-C_BASE_WIDTH){1'b0}}, w_tbl_base};
        end
        if (C_LENGTH_WIDTH >= C_ADDR_WIDTH) begin : g_len_trunc
            assign w_len = w_tbl_len[C_ADDR_WIDTH-1:0];
        end else begin : g_len_ext
            assign w_len = {{(C_ADDR_WIDTH-C_LENGTH_WIDTH){1'b0}}, w_tbl_len};
        end
    endgenerate

    assign w_sum   = {1'b0, r_a_addr} + {1'b0, w_base};
    assign w_fault = !tbl_match || (r_a_addr >= w_len) || w_sum[C_ADDR_WIDTH];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_a_valid <= 1'b0;
            r_a_src   <= SRC_AR;
            r_a_tag   <= '0;
            r_a_addr  <= '0;
        end else if (w_a_load) begin
            r_a_valid <= w_hs;
            if (w_hs) begin
                r_a_src  <= w_gnt_aw ? SRC_AW : SRC_AR;
                r_a_tag  <= w_gnt_aw ? aw_tag : ar_tag;
                r_a_addr <= w_gnt_aw ? aw_addr : ar_addr;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_b_valid <= 1'b0;
            r_b_src   <= SRC_AR;
            r_b_fault <= 1'b0;
            r_b_addr  <= '0;
        end else if (w_b_load) begin
            r_b_valid <= r_a_valid;
            if (w_a_to_b) begin
                r_b_src   <= r_a_src;
                r_b_fault <= w_fault;
                r_b_addr  <= w_fault ? '0 : w_sum[C_ADDR_WIDTH-1:0];
            end
        end
    end

    assign m_valid = r_b_valid;
    assign m_src   = r_b_src;
    assign m_fault = r_b_fault;
    assign m_addr  = r_b_addr;

`ifdef MIG_CP_XLAT_STATS_EN
    logic [C_CNT_WIDTH-1:0] r_xlat_cnt, r_fault_cnt;
    logic                   w_out_hs;

    assign w_out_hs = r_b_valid && m_ready;

    // Saturating counters: stop at all-ones rather than wrap.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_xlat_cnt  <= '0;
            r_fault_cnt <= '0;
        end else if (w_out_hs) begin
            if (!r_b_fault && (r_xlat_cnt != '1)) begin
                r_xlat_cnt <= r_xlat_cnt + 1'b1;
            end
            if (r_b_fault && (r_fault_cnt != '1)) begin
                r_fault_cnt <= r_fault_cnt + 1'b1;
            end
        end
    end

    assign stat_xlat_cnt  = r_xlat_cnt;
    assign stat_fault_cnt = r_fault_cnt;
`else
    assign stat_xlat_cnt  = '0;
    assign stat_fault_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mig_cp_xlat_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mig_cp_xlat_sched                                         |
// | Description : Directed self-checking bench for mig_cp_xlat_sched.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mig_cp_xlat_sched;
    import mig_cp_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        ar_valid = 1'b0, aw_valid = 1'b0, m_ready = 1'b1;
    logic [15:0] ar_tag = '0, aw_tag = '0;
    logic [31:0] ar_addr = '0, aw_addr = '0;
    logic        ar_ready, aw_ready, tbl_match, m_valid, m_src, m_fault;
    logic [15:0] tbl_tag;
    logic [63:0] tbl_data;
    logic [31:0] m_addr, stat_xlat_cnt, stat_fault_cnt;

    int n_asserts = 0;
    int n_fail    = 0;
    int exp_good  = 0;
    int exp_bad   = 0;

    always #5 aclk = ~aclk;

    mig_cp_xlat_sched dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .ar_valid       (ar_valid),
        .ar_ready       (ar_ready),
        .ar_tag         (ar_tag),
        .ar_addr        (ar_addr),
        .aw_valid       (aw_valid),
        .aw_ready       (aw_ready),
        .aw_tag         (aw_tag),
        .aw_addr        (aw_addr),
        .tbl_tag        (tbl_tag),
        .tbl_data       (tbl_data),
        .tbl_match      (tbl_match),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_addr         (m_addr),
        .m_src          (m_src),
        .m_fault        (m_fault),
        .stat_xlat_cnt  (stat_xlat_cnt),
        .stat_fault_cnt (stat_fault_cnt)
    );

    // Parameter table: {len, base}; tag 0x0002 intentionally absent.
    always_comb begin
        tbl_match = 1'b0;
        tbl_data  = '0;
        case (tbl_tag)
            16'h0001: begin tbl_match = 1'b1; tbl_data = {32'h0000_0100, 32'h1000_0000}; end
            16'h0003: begin tbl_match = 1'b1; tbl_data = {32'h0000_0200, 32'hFFFF_FF00}; end
            default:  begin tbl_match = 1'b0; tbl_data = '0; end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic check_stats(input string nm);
`ifdef MIG_CP_XLAT_STATS_EN
        check({nm, "_xlat_cnt"}, stat_xlat_cnt, exp_good);
        check({nm, "_fault_cnt"}, stat_fault_cnt, exp_bad);
`else
        check({nm, "_xlat_cnt"}, stat_xlat_cnt, 0);
        check({nm, "_fault_cnt"}, stat_fault_cnt, 0);
`endif
    endtask

    // Single isolated request: handshake now, result exactly two cycles later.
    task automatic xfer(input logic src, input logic [15:0] tag, input logic [31:0] addr,
                        input logic [31:0] e_addr, input logic e_fault, input string nm);
        if (src == SRC_AR) begin
            ar_valid = 1'b1; ar_tag = tag; ar_addr = addr;
        end else begin
            aw_valid = 1'b1; aw_tag = tag; aw_addr = addr;
        end
        #1;
        check({nm, "_ready"}, (src == SRC_AW) ? aw_ready : ar_ready, 1);
        tick();
        ar_valid = 1'b0;
        aw_valid = 1'b0;
        check({nm, "_valid_n1"}, m_valid, 0);
        check({nm, "_tbl_tag"}, tbl_tag, tag);
        tick();
        check({nm, "_valid_n2"}, m_valid, 1);
        check({nm, "_addr"}, m_addr, e_addr);
        check({nm, "_src"}, m_src, src);
        check({nm, "_fault"}, m_fault, e_fault);
        if (e_fault) exp_bad++;
        else exp_good++;
        tick();
        check({nm, "_drained"}, m_valid, 0);
    endtask

    logic [31:0] q_addr[$];
    logic        q_src[$];
    int          n_out;
    int          seq;
    logic        mr;

    initial begin
        tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_src", m_src, 0);
        check("rst_m_fault", m_fault, 0);
        check("rst_tbl_tag", tbl_tag, 0);
        check("rst_ar_ready", ar_ready, 0);
        check("rst_aw_ready", aw_ready, 0);
        check_stats("rst");
        aresetn = 1'b1;
        tick();

        xfer(SRC_AR, 16'h0001, 32'h0000_0040, 32'h1000_0040, 1'b0, "ar_hit");
        xfer(SRC_AW, 16'h0001, 32'h0000_0100, 32'h0000_0000, 1'b1, "aw_at_len");
        xfer(SRC_AW, 16'h0001, 32'h0000_00FF, 32'h1000_00FF, 1'b0, "aw_last_ok");
        xfer(SRC_AR, 16'h0002, 32'h0000_0010, 32'h0000_0000, 1'b1, "ar_miss");
        xfer(SRC_AR, 16'h0003, 32'h0000_0180, 32'h0000_0000, 1'b1, "ar_carry");
        xfer(SRC_AR, 16'h0003, 32'h0000_0080, 32'hFFFF_FF80, 1'b0, "ar_top");
        check_stats("after_xfers");

        // Fresh reset so the first tie goes to AR.
        exp_good = 0;
        exp_bad  = 0;
        do_reset();
        check_stats("after_reset");

        n_out = 0;
        for (int i = 0; i < 12; i++) begin
            check("alt_m_valid", m_valid, (i >= 2 && i < 10));
            if (m_valid && q_addr.size() > 0) begin
                check("alt_addr", m_addr, q_addr[0]);
                check("alt_src", m_src, q_src[0]);
                check("alt_fault", m_fault, 0);
                void'(q_addr.pop_front());
                void'(q_src.pop_front());
                n_out++;
            end
            ar_valid = (i < 8);
            aw_valid = (i < 8);
            ar_tag   = 16'h0001;
            aw_tag   = 16'h0001;
            ar_addr  = 32'h10 + i;
            aw_addr  = 32'h20 + i;
            #1;
            if (i < 8) begin
                check("alt_ar_ready", ar_ready, (i % 2 == 0));
                check("alt_aw_ready", aw_ready, (i % 2 == 1));
                q_src.push_back(i % 2 == 1);
                q_addr.push_back((i % 2 == 1) ? 32'h1000_0020 + i : 32'h1000_0010 + i);
            end
            tick();
        end
        check("alt_out_count", n_out, 8);

        // AR-only stream with a 5-cycle output stall.
        ar_valid = 1'b0;
        aw_valid = 1'b0;
        seq   = 0;
        n_out = 0;
        q_addr.delete();
        for (int i = 0; i < 20; i++) begin
            mr = !(i >= 4 && i < 9);
            if (i >= 5 && i < 9) check("bp_valid_held", m_valid, 1);
            if (m_valid) begin
                if (q_addr.size() > 0) check("bp_addr", m_addr, q_addr[0]);
                else check("bp_spurious_valid", m_valid, 0);
            end
            m_ready  = mr;
            ar_valid = (i < 12);
            ar_tag   = 16'h0001;
            ar_addr  = 32'h30 + seq;
            #1;
            if (i < 12) check("bp_ar_ready", ar_ready, (q_addr.size() < 2) || mr);
            if (m_valid && mr && q_addr.size() > 0) begin
                void'(q_addr.pop_front());
                n_out++;
            end
            if (ar_valid && ar_ready) begin
                q_addr.push_back(32'h1000_0030 + seq);
                seq++;
            end
            tick();
        end
        ar_valid = 1'b0;
        check("bp_in_out_equal", n_out, seq);
        check("bp_queue_empty", q_addr.size(), 0);

        // Fill both stages, then reset asynchronously mid-cycle.
        m_ready  = 1'b0;
        ar_valid = 1'b1;
        ar_tag   = 16'h0001;
        ar_addr  = 32'h50;
        tick();
        tick();
        ar_valid = 1'b0;
        check("full_m_valid", m_valid, 1);
        check("full_tbl_tag", tbl_tag, 16'h0001);
        aresetn = 1'b0;
        #1;
        check("async_rst_m_valid", m_valid, 0);
        check("async_rst_tbl_tag", tbl_tag, 0);
        check("async_rst_m_addr", m_addr, 0);
        check("async_rst_xlat_cnt", stat_xlat_cnt, 0);
        check("async_rst_fault_cnt", stat_fault_cnt, 0);
        tick();
        aresetn = 1'b1;
        m_ready = 1'b1;
        tick();
        tick();
        check("post_rst_dropped", m_valid, 0);
        exp_good = 0;
        exp_bad  = 0;
        xfer(SRC_AW, 16'h0001, 32'h0000_0004, 32'h1000_0004, 1'b0, "post_rst_aw");
        check_stats("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
